// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : shared ALU op codes, 16-bit sequencer op encoding and FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  // 8-bit ALU operation codes
  localparam logic [4:0] ALU_ZERO   = 5'd0;
  localparam logic [4:0] ALU_PASSA  = 5'd1;
  localparam logic [4:0] ALU_PASSB  = 5'd2;
  localparam logic [4:0] ALU_NOTA   = 5'd3;
  localparam logic [4:0] ALU_NOTB   = 5'd4;
  localparam logic [4:0] ALU_INCA   = 5'd5;
  localparam logic [4:0] ALU_INCB   = 5'd6;
  localparam logic [4:0] ALU_DECA   = 5'd7;
  localparam logic [4:0] ALU_DECB   = 5'd8;
  localparam logic [4:0] ALU_ADD    = 5'd9;
  localparam logic [4:0] ALU_ADC    = 5'd10;
  localparam logic [4:0] ALU_SUB    = 5'd11;
  localparam logic [4:0] ALU_NZERO  = 5'd12;
  localparam logic [4:0] ALU_SUBR   = 5'd13;
  localparam logic [4:0] ALU_SBB    = 5'd14;
  localparam logic [4:0] ALU_SBBR   = 5'd15;
  localparam logic [4:0] ALU_NEGA   = 5'd16;
  localparam logic [4:0] ALU_NEGB   = 5'd17;
  localparam logic [4:0] ALU_SHL    = 5'd18;
  localparam logic [4:0] ALU_SHR    = 5'd19;
  localparam logic [4:0] ALU_ASR    = 5'd20;
  localparam logic [4:0] ALU_ROL    = 5'd21;
  localparam logic [4:0] ALU_ROR    = 5'd22;
  localparam logic [4:0] ALU_RCL    = 5'd23;
  localparam logic [4:0] ALU_RCR    = 5'd24;
  localparam logic [4:0] ALU_AND    = 5'd25;
  localparam logic [4:0] ALU_OR     = 5'd26;
  localparam logic [4:0] ALU_XOR    = 5'd27;
  localparam logic [4:0] ALU_NAND   = 5'd28;
  localparam logic [4:0] ALU_NOR    = 5'd29;
  localparam logic [4:0] ALU_BCDADD = 5'd30;
  localparam logic [4:0] ALU_BCDSUB = 5'd31;

  // 16-bit request op encoding
  localparam logic [2:0] SEQ_ADD   = 3'd0;
  localparam logic [2:0] SEQ_SUB   = 3'd1;
  localparam logic [2:0] SEQ_INC   = 3'd2;
  localparam logic [2:0] SEQ_DEC   = 3'd3;
  localparam logic [2:0] SEQ_AND   = 3'd4;
  localparam logic [2:0] SEQ_OR    = 3'd5;
  localparam logic [2:0] SEQ_XOR   = 3'd6;
  localparam logic [2:0] SEQ_PASSB = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu16_opsel.sv
// ============================================================================
// alu16_opsel : maps a 16-bit request op, byte phase and low-byte carry to the
//               8-bit ALU op code
// Rev 1.0
// ============================================================================
`default_nettype none

module alu16_opsel
  import alu_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic       i_high,
  input  logic       i_c_lo,
  output logic [4:0] o_alu_op
);

  always_comb begin
    o_alu_op = ALU_ZERO;
    case (i_op)
      SEQ_ADD:   o_alu_op = (i_high && i_c_lo) ? ALU_ADC : ALU_ADD;
      SEQ_SUB:   o_alu_op = (i_high && i_c_lo) ? ALU_SBB : ALU_SUB;
      // High byte of INC/DEC only moves when the low byte wrapped
      SEQ_INC:   o_alu_op = (i_high && !i_c_lo) ? ALU_PASSA : ALU_INCA;
      SEQ_DEC:   o_alu_op = (i_high && !i_c_lo) ? ALU_PASSA : ALU_DECA;
      SEQ_AND:   o_alu_op = ALU_AND;
      SEQ_OR:    o_alu_op = ALU_OR;
      SEQ_XOR:   o_alu_op = ALU_XOR;
      SEQ_PASSB: o_alu_op = ALU_PASSB;
      default:   o_alu_op = ALU_ZERO;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu16_seq.sv
// ============================================================================
// alu16_seq : 16-bit ALU front end executing each request as two byte passes
//             through an external 8-bit ALU with carry chaining
// Rev 1.0
// ============================================================================
`default_nettype none

module alu16_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_zero,
  output logic        rsp_negative,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [4:0]  alu_op,
  input  logic [7:0]  alu_result,
  input  logic        alu_carry,
  input  logic        alu_zero
);

  state_t      r_state;
  logic [2:0]  r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_c_lo;
  logic [7:0]  r_res_lo;
  logic [7:0]  r_res_hi;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic        r_carry;
  logic        r_zero;
  logic        r_neg;

  logic [4:0]  w_opsel;
  logic        w_high;
  logic        w_unused;

  // Zero is derived from the full 16-bit result, so the ALU's flag is ignored
  assign w_unused = alu_zero;
  assign w_high   = (r_state == ST_HIGH);

  alu16_opsel u_opsel (
    .i_op     (r_op),
    .i_high   (w_high),
    .i_c_lo   (r_c_lo),
    .o_alu_op (w_opsel)
  );

  always_comb begin
    alu_a  = 8'd0;
    alu_b  = 8'd0;
    alu_op = ALU_ZERO;
    case (r_state)
      ST_LOW: begin
        alu_a  = r_a[7:0];
        alu_b  = r_b[7:0];
        alu_op = w_opsel;
      end
      ST_HIGH: begin
        alu_a  = r_a[15:8];
        alu_b  = r_b[15:8];
        alu_op = w_opsel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= 3'd0;
      r_a         <= 16'd0;
      r_b         <= 16'd0;
      r_c_lo      <= 1'b0;
      r_res_lo    <= 8'd0;
      r_res_hi    <= 8'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op        <= req_op;
            r_a         <= req_a;
            r_b         <= req_b;
            r_req_ready <= 1'b0;
            r_state     <= ST_LOW;
          end
        end
        ST_LOW: begin
          r_res_lo <= alu_result;
          r_c_lo   <= alu_carry;
          r_state  <= ST_HIGH;
        end
        ST_HIGH: begin
          r_res_hi <= alu_result;
          r_carry  <= alu_carry;
          r_zero   <= ({alu_result, r_res_lo} == 16'd0);
          r_neg    <= alu_result[7];
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          // rsp_valid rises one cycle after entering DONE
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_result   = {r_res_hi, r_res_lo};
  assign rsp_carry    = r_carry;
  assign rsp_zero     = r_zero;
  assign rsp_negative = r_neg;

endmodule

`default_nettype wire

// File: tb/tb_alu16_seq.sv
// ============================================================================
// tb_alu16_seq : directed self-checking bench for alu16_seq with an 8-bit ALU
//                behavioural model on the ALU side
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu16_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_zero;
  logic        rsp_negative;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [4:0]  alu_op;
  logic [7:0]  alu_result;
  logic        alu_carry;
  logic        alu_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu16_seq dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_zero     (rsp_zero),
    .rsp_negative (rsp_negative),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero)
  );

  // 8-bit ALU model for the op codes this block issues; bit 8 is carry/borrow
  logic [8:0] w_sum;
  always_comb begin
    w_sum = 9'd0;
    case (alu_op)
      5'd1:  w_sum = {1'b0, alu_a};
      5'd2:  w_sum = {1'b0, alu_b};
      5'd5:  w_sum = {1'b0, alu_a} + 9'd1;
      5'd7:  w_sum = {1'b0, alu_a} - 9'd1;
      5'd9:  w_sum = {1'b0, alu_a} + {1'b0, alu_b};
      5'd10: w_sum = {1'b0, alu_a} + {1'b0, alu_b} + 9'd1;
      5'd11: w_sum = {1'b0, alu_a} - {1'b0, alu_b};
      5'd14: w_sum = {1'b0, alu_a} - {1'b0, alu_b} - 9'd1;
      5'd25: w_sum = {1'b0, alu_a & alu_b};
      5'd26: w_sum = {1'b0, alu_a | alu_b};
      5'd27: w_sum = {1'b0, alu_a ^ alu_b};
      default: w_sum = 9'd0;
    endcase
  end
  assign alu_result = w_sum[7:0];
  assign alu_carry  = w_sum[8];
  assign alu_zero   = (w_sum[7:0] == 8'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge; returns with rsp_valid up
  task automatic start_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [4:0] exp_lo, input logic [4:0] exp_hi);
    check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 3'd6;
    req_a     = 16'h5A5A;
    req_b     = 16'hC3C3;
    check({tag, ".lo_op"}, {27'd0, alu_op}, {27'd0, exp_lo});
    check({tag, ".lo_a"}, {24'd0, alu_a}, {24'd0, a[7:0]});
    check({tag, ".busy"}, {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check({tag, ".hi_op"}, {27'd0, alu_op}, {27'd0, exp_hi});
    check({tag, ".hi_b"}, {24'd0, alu_b}, {24'd0, b[15:8]});
    @(posedge clk); #1;
    check({tag, ".early_valid"}, {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic check_rsp(input string tag, input logic [15:0] res, input logic c,
                           input logic z, input logic n);
    check({tag, ".result"}, {16'd0, rsp_result}, {16'd0, res});
    check({tag, ".flags"}, {29'd0, rsp_carry, rsp_zero, rsp_negative}, {29'd0, c, z, n});
  endtask

  task automatic finish_op(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, ".ready_back"}, {31'd0, req_ready}, 32'd1);
    check({tag, ".valid_drop"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [4:0] exp_lo, input logic [4:0] exp_hi,
                        input logic [15:0] res, input logic c, input logic z, input logic n);
    start_op(tag, op, a, b, exp_lo, exp_hi);
    check_rsp(tag, res, c, z, n);
    finish_op(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = 16'd0;
    req_b     = 16'd0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.req_ready", {31'd0, req_ready}, 32'd1);
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_rsp("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    check("rst.alu", {11'd0, alu_op, alu_a, alu_b}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    //     tag        op   a         b         lo     hi     result    c     z     n
    run_op("add1",   3'd0, 16'h12FF, 16'h0001, 5'd9,  5'd10, 16'h1300, 1'b0, 1'b0, 1'b0);
    run_op("add2",   3'd0, 16'hFFFF, 16'h0001, 5'd9,  5'd10, 16'h0000, 1'b1, 1'b1, 1'b0);
    run_op("sub1",   3'd1, 16'h1000, 16'h0001, 5'd11, 5'd14, 16'h0FFF, 1'b0, 1'b0, 1'b0);
    run_op("sub2",   3'd1, 16'h0000, 16'h0001, 5'd11, 5'd14, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    run_op("inc1",   3'd2, 16'h00FF, 16'h0000, 5'd5,  5'd5,  16'h0100, 1'b0, 1'b0, 1'b0);
    run_op("dec1",   3'd3, 16'h0100, 16'h0000, 5'd7,  5'd7,  16'h00FF, 1'b0, 1'b0, 1'b0);
    run_op("inc2",   3'd2, 16'h1234, 16'h0000, 5'd5,  5'd1,  16'h1235, 1'b0, 1'b0, 1'b0);
    run_op("passb",  3'd7, 16'h1111, 16'h8000, 5'd2,  5'd2,  16'h8000, 1'b0, 1'b0, 1'b1);

    // Backpressure: response held 5 cycles, a request pulse in between is dropped
    start_op("bp", 3'd6, 16'hA5A5, 16'h0FF0, 5'd27, 5'd27);
    for (int i = 0; i < 5; i++) begin
      req_valid = (i == 2);
      req_op    = 3'd0;
      req_a     = 16'h0001;
      req_b     = 16'h0001;
      @(posedge clk); #1;
      check_rsp("bp.hold", 16'hAA55, 1'b0, 1'b0, 1'b1);
      check("bp.hold_valid", {30'd0, rsp_valid, req_ready}, 32'd2);
    end
    req_valid = 1'b0;
    finish_op("bp");
    @(posedge clk); #1;
    check("bp.no_ghost", {30'd0, rsp_valid, req_ready}, 32'd1);
    check("bp.no_ghost_op", {27'd0, alu_op}, 32'd0);

    // Reset asserted mid-operation during the HIGH pass
    req_valid = 1'b1;
    req_op    = 3'd5;
    req_a     = 16'h1200;
    req_b     = 16'h0034;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_hi.op", {27'd0, alu_op}, 32'd26);
    #2 reset = 1'b1;
    #1;
    check("rst_hi.ready", {30'd0, rsp_valid, req_ready}, 32'd1);
    check_rsp("rst_hi", 16'h0000, 1'b0, 1'b0, 1'b0);
    check("rst_hi.alu", {11'd0, alu_op, alu_a, alu_b}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_hi.no_rsp", {30'd0, rsp_valid, req_ready}, 32'd1);
    end

    run_op("and1",   3'd4, 16'hF0F0, 16'h0FF0, 5'd25, 5'd25, 16'h00F0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
